// File: rtl/pwm_capture_pkg.sv
// Shared constants and state encoding for the PWM capture block.
// Glitch filter is enabled with PWM_CAPTURE_GLITCH_FILTER_EN.
package pwm_capture_pkg;

    localparam int PWM_DUTY_W      = 10;
    localparam int PWM_PERIOD      = 1024;
    localparam int PWM_TIMEOUT     = 2048;
    localparam int PWM_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } cap_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Input synchronizer, optional 3-sample majority filter and rise detect.
// Filter built in when PWM_CAPTURE_GLITCH_FILTER_EN is defined.
module pwm_edge_sync
    import pwm_capture_pkg::*;
#(
    parameter int SYNC_STAGES = PWM_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pwm,
    output logic o_pwm_s,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   pwm_s;
    logic                   prev_q;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], i_pwm};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       maj_q;
    logic       maj_d;
    logic       samp;

    assign samp  = sync_q[SYNC_STAGES-1];
    // Majority of the newest sample and the two before it.
    assign maj_d = (samp & hist_q[0]) | (samp & hist_q[1])
                 | (hist_q[0] & hist_q[1]);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            hist_q <= '0;
            maj_q  <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], samp};
            maj_q  <= maj_d;
        end
    end

    assign pwm_s = maj_q;
`else
    assign pwm_s = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= pwm_s;
        end
    end

    assign o_pwm_s = pwm_s;
    assign o_rise  = pwm_s & ~prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Recovers duty code and period from a sampled PWM waveform.
// Optional majority filter via PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int DUTY_W      = PWM_DUTY_W,
    parameter int PERIOD      = PWM_PERIOD,
    parameter int TIMEOUT     = PWM_TIMEOUT,
    parameter int SYNC_STAGES = PWM_SYNC_STAGES
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pwm,
    output logic [DUTY_W-1:0] o_duty,
    output logic [DUTY_W:0]   o_period,
    output logic              o_valid,
    output logic              o_err,
    output logic              o_stuck,
    output logic              o_locked
);

    localparam int PW = DUTY_W + 2;
    localparam int HW = DUTY_W + 1;
    localparam logic [HW-1:0] HI_MAX  = HW'((1 << DUTY_W) - 1);
    localparam logic [PW-1:0] PER_MAX = PW'((1 << (DUTY_W + 1)) - 1);

    logic pwm_s;
    logic rise;

    pwm_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_pwm  (i_pwm),
        .o_pwm_s(pwm_s),
        .o_rise (rise)
    );

    cap_state_e        state_q, state_d;
    logic [PW-1:0]     per_q, per_d;
    logic [HW-1:0]     hi_q, hi_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W:0]   period_q, period_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              stuck_q, stuck_d;
    logic              pub_meas;
    logic              pub_stuck;

    // Counters restart at 1 on a rise and saturate instead of wrapping.
    always_comb begin
        per_d = per_q;
        hi_d  = hi_q;
        if (rise) begin
            per_d = PW'(1);
            hi_d  = HW'(1);
        end else begin
            if (per_q != '1) begin
                per_d = per_q + PW'(1);
            end
            if (pwm_s && (hi_q != '1)) begin
                hi_d = hi_q + HW'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pub_meas  = 1'b0;
        pub_stuck = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = ARMED;
                end
            end
            ARMED, LOCKED: begin
                if (rise) begin
                    state_d  = LOCKED;
                    pub_meas = 1'b1;
                end else if (per_q == PW'(TIMEOUT)) begin
                    state_d   = IDLE;
                    pub_stuck = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        duty_d   = duty_q;
        period_d = period_q;
        err_d    = err_q;
        stuck_d  = stuck_q;
        valid_d  = 1'b0;
        if (pub_meas) begin
            duty_d   = (hi_q > HI_MAX) ? '1 : hi_q[DUTY_W-1:0];
            period_d = (per_q > PER_MAX) ? '1 : per_q[DUTY_W:0];
            err_d    = (per_q != PW'(PERIOD)) | (hi_q > HI_MAX);
            stuck_d  = 1'b0;
            valid_d  = 1'b1;
        end else if (pub_stuck) begin
            duty_d   = pwm_s ? '1 : '0;
            period_d = '0;
            err_d    = 1'b0;
            stuck_d  = 1'b1;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            per_q    <= '0;
            hi_q     <= '0;
            duty_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            per_q    <= per_d;
            hi_q     <= hi_d;
            duty_q   <= duty_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            stuck_q  <= stuck_d;
        end
    end

    assign o_duty   = duty_q;
    assign o_period = period_q;
    assign o_valid  = valid_q;
    assign o_err    = err_q;
    assign o_stuck  = stuck_q;
    assign o_locked = (state_q == LOCKED);

endmodule

// File: tb/tb_pwm_capture.sv
// Directed and randomized PWM waveforms against an arithmetic reference.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pwm;
    logic [9:0]  duty;
    logic [10:0] period;
    logic        valid;
    logic        err;
    logic        stuck;
    logic        locked;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif
    localparam int TMO = 2048;

    always #10 clk = ~clk;

    pwm_capture dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_pwm   (pwm),
        .o_duty  (duty),
        .o_period(period),
        .o_valid (valid),
        .o_err   (err),
        .o_stuck (stuck),
        .o_locked(locked)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int nvalid = 0;
    int r_duty, r_period, r_err, r_stuck, r_locked, r_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            nvalid   <= nvalid + 1;
            r_duty   <= int'(duty);
            r_period <= int'(period);
            r_err    <= int'(err);
            r_stuck  <= int'(stuck);
            r_locked <= int'(locked);
            r_cyc    <= cyc;
        end
    end

    int prev_open = 0;
    int prev_h    = 0;
    int prev_p    = 0;
    int last_rise = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One PWM period of p clocks, h high, optional 1-clock low glitch at g.
    task automatic run_period(input int h, input int p, input int g);
        int v0, st, split;
        v0 = nvalid;
        st = cyc;
        last_rise = cyc;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        split = 0;
`else
        split = (g >= 0) ? 1 : 0;
`endif
        for (int i = 0; i < p; i++) begin
            pwm = (i < h) && (i != g);
            tick();
        end
        chk("n_valid", nvalid - v0, prev_open + split);
        if (split != 0) begin
            chk("g_duty", r_duty, g);
            chk("g_period", r_period, g + 1);
            chk("g_err", r_err, 1);
            chk("g_locked", r_locked, 1);
            chk("g_lat", r_cyc - st, g + 1 + LAT);
        end else if (prev_open != 0) begin
            chk("duty", r_duty, imin(prev_h, 1023));
            chk("period", r_period, imin(prev_p, 2047));
            chk("err", r_err,
                ((prev_p != 1024) || (prev_h > 1023)) ? 1 : 0);
            chk("stuck", r_stuck, 0);
            chk("locked", r_locked, 1);
            chk("lat", r_cyc - st, LAT);
        end
        if (split != 0) begin
            prev_h = h - g - 1;
            prev_p = p - g - 1;
        end else begin
            prev_h = h;
            prev_p = p;
        end
        prev_open = 1;
    endtask

    task automatic hold(input int level, input int n);
        int v0, t0;
        v0 = nvalid;
        t0 = (level != 0) ? cyc : last_rise;
        for (int i = 0; i < n; i++) begin
            pwm = (level != 0);
            tick();
        end
        chk("s_count", nvalid - v0, 1);
        chk("s_duty", r_duty, (level != 0) ? 1023 : 0);
        chk("s_period", r_period, 0);
        chk("s_err", r_err, 0);
        chk("s_stuck", r_stuck, 1);
        chk("s_locked", r_locked, 0);
        chk("s_lat", r_cyc - t0, TMO + LAT);
        prev_open = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_duty"}, int'(duty), 0);
        chk({tag, "_period"}, int'(period), 0);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_stuck"}, int'(stuck), 0);
        chk({tag, "_locked"}, int'(locked), 0);
    endtask

    initial begin
        int h, p, v0, st;
        rst_n = 1'b0;
        pwm   = 1'b0;
        repeat (4) tick();
        chk_zero("rst");
        rst_n = 1'b1;
        tick();

        repeat (3) run_period(512, 1024, -1);
        chk("lock_now", int'(locked), 1);
        repeat (2) run_period(255, 1024, -1);
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
        run_period(1, 1024, -1);
        run_period(1023, 1024, -1);
`endif
        for (int k = 0; k < 6; k++) begin
            h = int'($urandom_range(1022, 2));
            run_period(h, 1024, -1);
        end
        for (int k = 0; k < 4; k++) begin
            p = int'($urandom_range(1100, 900));
            h = int'($urandom_range(p - 2, 2));
            run_period(h, p, -1);
        end
        run_period(300, 1000, -1);
        run_period(1200, 1500, -1);
        run_period(100, 2048, -1);
        run_period(600, 1024, -1);
        run_period(600, 1024, 200);
        run_period(600, 1024, -1);

        run_period(100, 1024, -1);
        run_period(100, 1024, -1);
        v0 = nvalid;
        st = cyc;
        for (int i = 0; i < 500; i++) begin
            pwm = (i < 100);
            tick();
        end
        chk("pre_rst_n", nvalid - v0, 1);
        chk("pre_rst_duty", r_duty, 100);
        chk("pre_rst_lat", r_cyc - st, LAT);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_zero("mid_rst");
        for (int i = 0; i < 523; i++) begin
            pwm = 1'b0;
            tick();
        end
        prev_open = 0;
        run_period(100, 1024, -1);
        run_period(100, 1024, -1);

        hold(0, 3000);
        hold(1, 3000);
        v0 = nvalid;
        for (int i = 0; i < 20; i++) begin
            pwm = 1'b0;
            tick();
        end
        chk("settle_n", nvalid - v0, 0);
        run_period(400, 1024, -1);
        run_period(400, 1024, -1);
        run_period(700, 1024, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
